// File: rtl/i2c_resp_pkg.sv
// rtl/i2c_resp_pkg.sv - shared types and constants for the I2C responder
package i2c_resp_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_LOAD,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_WAIT_STOP
    } i2c_resp_state_t;

    typedef enum logic {
        I2C_WRITE = 1'b0,
        I2C_READ  = 1'b1
    } i2c_op_t;

    localparam logic I2C_ACK    = 1'b0;
    localparam logic I2C_NACK   = 1'b1;
    localparam int   SYNC_DEPTH = 2;

endpackage

// File: rtl/i2c_bus_cond_det.sv
// rtl/i2c_bus_cond_det.sv - SCL/SDA synchronizer with edge, START and STOP pulses
module i2c_bus_cond_det
    import i2c_resp_pkg::*;
(
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o,
    output logic sda_lvl_o
);

    logic [SYNC_DEPTH-1:0] scl_sync;
    logic [SYNC_DEPTH-1:0] sda_sync;
    logic [SYNC_DEPTH:0]   arm;
    logic                  scl_d;
    logic                  sda_d;
    logic                  scl_s;
    logic                  sda_s;
    logic                  live;

    assign scl_s     = scl_sync[SYNC_DEPTH-1];
    assign sda_s     = sda_sync[SYNC_DEPTH-1];
    assign sda_lvl_o = sda_d;
    // Events stay masked until the chain and edge register hold real bus values.
    assign live      = arm[SYNC_DEPTH];

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            scl_sync   <= '1;
            sda_sync   <= '1;
            scl_d      <= 1'b1;
            sda_d      <= 1'b1;
            arm        <= '0;
            scl_rise_o <= 1'b0;
            scl_fall_o <= 1'b0;
            start_o    <= 1'b0;
            stop_o     <= 1'b0;
        end else begin
            scl_sync   <= {scl_sync[SYNC_DEPTH-2:0], scl_i};
            sda_sync   <= {sda_sync[SYNC_DEPTH-2:0], sda_i};
            scl_d      <= scl_s;
            sda_d      <= sda_s;
            arm        <= {arm[SYNC_DEPTH-1:0], 1'b1};
            scl_rise_o <= live & scl_s & ~scl_d;
            scl_fall_o <= live & ~scl_s & scl_d;
            start_o    <= live & scl_d & sda_d & ~sda_s;
            stop_o     <= live & scl_d & ~sda_d & sda_s;
        end
    end

endmodule

// File: rtl/i2c_resp_slave.sv
// rtl/i2c_resp_slave.sv - I2C target with byte sink/source; I2C_RESP_CLK_STRETCH_EN enables SCL stretching on reads
module i2c_resp_slave
    import i2c_resp_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 7,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] SLAVE_ADDR = 7'h22
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  scl_o,
    output logic                  sda_o,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    output logic                  wr_valid_o,
    output logic                  rd_req_o,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    input  logic                  rd_valid_i,
    output logic                  busy_o,
    output logic                  op_o,
    output logic                  nack_o,
    output logic                  underrun_o
);

    localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

    logic scl_rise, scl_fall, start, stop, sda_lvl;

    i2c_bus_cond_det u_cond_det (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start),
        .stop_o     (stop),
        .sda_lvl_o  (sda_lvl)
    );

    i2c_resp_state_t       state, state_n;
    i2c_op_t               op_q, op_n;
    logic [3:0]            bit_cnt, bit_cnt_n;
    logic [DATA_WIDTH-1:0] shreg, shreg_n, rx_byte;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_n;
    logic                  phase, phase_n;
    logic                  sda_q, sda_n;
    logic                  busy_q, busy_n;
    logic                  wr_valid_n, rd_req_n, nack_n, underrun_n;
`ifdef I2C_RESP_CLK_STRETCH_EN
    logic                  scl_q, scl_n;
    assign scl_o = scl_q;
`else
    assign scl_o = 1'b1;
`endif

    assign sda_o     = sda_q;
    assign wr_data_o = wr_data_q;
    assign busy_o    = busy_q;
    assign op_o      = op_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state      <= ST_IDLE;
            op_q       <= I2C_WRITE;
            bit_cnt    <= '0;
            shreg      <= '0;
            wr_data_q  <= '0;
            phase      <= 1'b0;
            sda_q      <= 1'b1;
            busy_q     <= 1'b0;
            wr_valid_o <= 1'b0;
            rd_req_o   <= 1'b0;
            nack_o     <= 1'b0;
            underrun_o <= 1'b0;
`ifdef I2C_RESP_CLK_STRETCH_EN
            scl_q      <= 1'b1;
`endif
        end else begin
            state      <= state_n;
            op_q       <= op_n;
            bit_cnt    <= bit_cnt_n;
            shreg      <= shreg_n;
            wr_data_q  <= wr_data_n;
            phase      <= phase_n;
            sda_q      <= sda_n;
            busy_q     <= busy_n;
            wr_valid_o <= wr_valid_n;
            rd_req_o   <= rd_req_n;
            nack_o     <= nack_n;
            underrun_o <= underrun_n;
`ifdef I2C_RESP_CLK_STRETCH_EN
            scl_q      <= scl_n;
`endif
        end
    end

    always_comb begin
        state_n    = state;
        op_n       = op_q;
        bit_cnt_n  = bit_cnt;
        shreg_n    = shreg;
        wr_data_n  = wr_data_q;
        phase_n    = phase;
        sda_n      = sda_q;
        busy_n     = busy_q;
        wr_valid_n = 1'b0;
        rd_req_n   = 1'b0;
        nack_n     = 1'b0;
        underrun_n = 1'b0;
        rx_byte    = {shreg[DATA_WIDTH-2:0], sda_lvl};
`ifdef I2C_RESP_CLK_STRETCH_EN
        scl_n      = scl_q;
`endif
        if (stop || start) begin
            // A repeated START drops any partial byte; STOP returns to idle.
            state_n   = stop ? ST_IDLE : ST_ADDR;
            busy_n    = start;
            bit_cnt_n = '0;
            phase_n   = 1'b0;
            sda_n     = 1'b1;
`ifdef I2C_RESP_CLK_STRETCH_EN
            scl_n     = 1'b1;
`endif
        end else begin
            case (state)
                ST_ADDR, ST_WR_DATA: if (scl_rise) begin
                    shreg_n   = rx_byte;
                    bit_cnt_n = bit_cnt + 4'd1;
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_n = '0;
                        if (state == ST_WR_DATA) begin
                            wr_data_n  = rx_byte;
                            wr_valid_n = 1'b1;
                            state_n    = ST_WR_ACK;
                        end else if (rx_byte[DATA_WIDTH-1:1] == SLAVE_ADDR) begin
                            op_n    = i2c_op_t'(rx_byte[0]);
                            state_n = ST_ADDR_ACK;
                        end else begin
                            state_n = ST_WAIT_STOP;
                        end
                    end
                end
                // First fall starts the ACK low, second fall ends the ninth clock.
                ST_ADDR_ACK, ST_WR_ACK: if (scl_fall) begin
                    phase_n = ~phase;
                    sda_n   = phase ? 1'b1 : I2C_ACK;
                    if (phase) begin
                        if (op_q == I2C_READ) begin
                            state_n  = ST_RD_LOAD;
                            rd_req_n = 1'b1;
`ifdef I2C_RESP_CLK_STRETCH_EN
                            scl_n    = 1'b0;
`endif
                        end else begin
                            state_n = ST_WR_DATA;
                        end
                    end
                end
                ST_RD_LOAD: begin
`ifdef I2C_RESP_CLK_STRETCH_EN
                    if (rd_valid_i) begin
                        shreg_n   = rd_data_i;
                        sda_n     = rd_data_i[DATA_WIDTH-1];
                        scl_n     = 1'b1;
                        bit_cnt_n = '0;
                        state_n   = ST_RD_DATA;
                    end
`else
                    shreg_n    = rd_valid_i ? rd_data_i : '1;
                    underrun_n = ~rd_valid_i;
                    sda_n      = shreg_n[DATA_WIDTH-1];
                    bit_cnt_n  = '0;
                    state_n    = ST_RD_DATA;
`endif
                end
                ST_RD_DATA: begin
                    if (scl_rise) begin
                        bit_cnt_n = bit_cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt > LAST_BIT) begin
                            sda_n     = 1'b1;
                            bit_cnt_n = '0;
                            state_n   = ST_RD_ACK;
                        end else begin
                            shreg_n = shreg << 1;
                            sda_n   = shreg[DATA_WIDTH-2];
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_lvl == I2C_NACK) begin
                            nack_n  = 1'b1;
                            state_n = ST_WAIT_STOP;
                        end else begin
                            phase_n = 1'b1;
                        end
                    end else if (scl_fall && phase) begin
                        phase_n  = 1'b0;
                        rd_req_n = 1'b1;
                        state_n  = ST_RD_LOAD;
`ifdef I2C_RESP_CLK_STRETCH_EN
                        scl_n    = 1'b0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
